// File: rtl/mire_pkg.sv
// Shared types and constants for the mire_gen framebuffer test-pattern writer.
package mire_pkg;

  typedef enum logic [1:0] {
    MODE_GRID    = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_SOLID   = 2'd3
  } mode_e;

  localparam logic [15:0] C_WHITE   = 16'hFFFF;
  localparam logic [15:0] C_YELLOW  = 16'hFFE0;
  localparam logic [15:0] C_CYAN    = 16'h07FF;
  localparam logic [15:0] C_GREEN   = 16'h07E0;
  localparam logic [15:0] C_MAGENTA = 16'hF81F;
  localparam logic [15:0] C_RED     = 16'hF800;
  localparam logic [15:0] C_BLUE    = 16'h001F;
  localparam logic [15:0] C_BLACK   = 16'h0000;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_BURST = 2'd1;
  localparam state_t ST_PAUSE = 2'd2;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/mire_pattern.sv
// Combinational pixel colour for (x, y) under the selected test pattern.
module mire_pattern
  import mire_pkg::*;
#(
  parameter int          HDISP = 640,
  parameter int          GRID  = 16,
  parameter int          XW    = 10,
  parameter int          YW    = 9,
  parameter logic [15:0] FILL  = 16'hF800
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [1:0]    mode,
  output logic [15:0]   col
);

  localparam int GL = $clog2(GRID);

  logic [31:0] xw, yw, bar;

  assign xw  = 32'(x);
  assign yw  = 32'(y);
  assign bar = (xw * 32'd8) / 32'(HDISP);

  always_comb begin
    col = C_BLACK;
    case (mode)
      MODE_GRID: begin
        if ((xw & 32'(GRID - 1)) == 32'd0 || (yw & 32'(GRID - 1)) == 32'd0) col = C_WHITE;
      end
      MODE_BARS: begin
        case (bar)
          32'd0:   col = C_WHITE;
          32'd1:   col = C_YELLOW;
          32'd2:   col = C_CYAN;
          32'd3:   col = C_GREEN;
          32'd4:   col = C_MAGENTA;
          32'd5:   col = C_RED;
          32'd6:   col = C_BLUE;
          default: col = C_BLACK;
        endcase
      end
      MODE_CHECKER: begin
        if ((((xw >> GL) ^ (yw >> GL)) & 32'd1) != 32'd0) col = C_WHITE;
      end
      default: col = FILL;
    endcase
  end

endmodule

// File: rtl/mire_gen.sv
// Wishbone test-pattern writer: bursts of BURST pixels separated by PAUSE idle cycles.
// Define MIRE_GEN_CTI_EN to emit incrementing-burst cycle type tags.
module mire_gen
  import mire_pkg::*;
#(
  parameter int                HDISP    = 640,
  parameter int                VDISP    = 480,
  parameter int                GRID     = 16,
  parameter int                BURST    = 64,
  parameter int                PAUSE    = 64,
  parameter int                ADR_W    = 32,
  parameter logic [ADR_W-1:0]  BASE_ADR = '0,
  parameter logic [15:0]       FILL     = 16'hF800
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  output logic [ADR_W-1:0] adr,
  output logic [15:0]      dat_ms,
  output logic             we,
  output logic [1:0]       sel,
  output logic             stb,
  output logic             cyc,
  output logic [2:0]       cti,
  output logic [1:0]       bte,
  input  logic             ack,
  output logic             frame_done
);

  localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int BW = $clog2(BURST + 1);
  localparam int PW = $clog2(PAUSE + 1);

  state_t          state;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [BW-1:0]   bcnt;
  logic [PW-1:0]   pcnt;
  logic [1:0]      mode_q;
  logic            fresh;
  logic            last_x, last_y, last_pix, last_beat;
  logic [ADR_W-1:0] lin;

  assign last_x    = (x == XW'(HDISP - 1));
  assign last_y    = (y == YW'(VDISP - 1));
  assign last_pix  = last_x && last_y;
  assign last_beat = (bcnt == BW'(BURST - 1)) || last_pix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      x          <= '0;
      y          <= '0;
      bcnt       <= '0;
      pcnt       <= '0;
      mode_q     <= '0;
      fresh      <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == ST_BURST) && ack && last_pix;
      // First clock out of reset picks up the requested pattern.
      if (fresh) begin
        mode_q <= mode;
        fresh  <= 1'b0;
      end
      case (state)
        ST_IDLE: if (enable) state <= ST_BURST;
        ST_BURST: begin
          if (ack) begin
            x <= last_x ? '0 : x + XW'(1);
            if (last_x) y <= last_y ? '0 : y + YW'(1);
            if (last_pix) mode_q <= mode;
            if (last_beat) begin
              bcnt  <= '0;
              pcnt  <= '0;
              state <= ST_PAUSE;
            end else begin
              bcnt <= bcnt + BW'(1);
            end
          end
        end
        ST_PAUSE: begin
          if (pcnt == PW'(PAUSE - 1)) state <= enable ? ST_BURST : ST_IDLE;
          else pcnt <= pcnt + PW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign lin = ADR_W'(y) * ADR_W'(HDISP) + ADR_W'(x);
  assign adr = BASE_ADR + (lin << 1);

  assign cyc = (state == ST_BURST);
  assign stb = cyc;
  assign we  = 1'b1;
  assign sel = 2'b11;
  assign bte = 2'b00;

`ifdef MIRE_GEN_CTI_EN
  assign cti = cyc ? (last_beat ? CTI_EOB : CTI_INCR) : CTI_CLASSIC;
`else
  assign cti = CTI_CLASSIC;
`endif

  mire_pattern #(
    .HDISP (HDISP),
    .GRID  (GRID),
    .XW    (XW),
    .YW    (YW),
    .FILL  (FILL)
  ) u_pattern (
    .x    (x),
    .y    (y),
    .mode (mode_q),
    .col  (dat_ms)
  );

endmodule
